input_debouncer: RTL and testbench

- Multi-lane input conditioner that sits directly upstream of the d_ff / t_ff / jk_ff stages.
- Each lane takes a raw, asynchronous, possibly bouncing bit, synchronises it into clk, and filters it.
- Each lane drives a clean level plus one-cycle rise/fall pulses. The pulses are suitable as t or j/k enables.
- Lanes are fully independent; WIDTH matches the flip-flop bank width.

---
 rtl/seq_pkg.sv | 39 +++
 rtl/input_debouncer_lane.sv | 123 ++++++++++++
 rtl/input_debouncer.sv | 65 ++++++
 tb/tb_input_debouncer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
//
// Shared definitions for the sequential-element slice (input conditioning and
// the d_ff / t_ff / jk_ff banks that consume it).
//
// Contents:
//   cnt_width(n)        width of a counter that must reach n-1, never below 1
//   DEF_SYNC_STAGES     default synchroniser depth for sibling blocks
//   DEF_STABLE_CYCLES   default debounce hold time, in post-sync cycles
//   lane_act_e          per-cycle decision taken by one debounce lane
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 8;

    // A counter that runs 0..n-1 needs $clog2(n) bits. For n==1 that would be
    // zero bits, so clamp to one to keep the declaration legal.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // What a debounce lane does at the next edge.
    //   ACT_HOLD   : synchronised value agrees with dout, counter is cleared
    //   ACT_COUNT  : value differs, still accumulating stable cycles
    //   ACT_COMMIT : value has been stable long enough, dout takes it
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_COUNT  = 2'd1,
        ACT_COMMIT = 2'd2
    } lane_act_e;

endpackage : seq_pkg

// File: rtl/input_debouncer_lane.sv
// -----------------------------------------------------------------------------
// debounce_lane
//
// One bit of the input conditioner: a SYNC_STAGES-deep synchroniser followed
// by a stability counter. dout only moves once the synchronised value has
// differed from it for STABLE_CYCLES consecutive edges; any sample that agrees
// with dout restarts the count. rise/fall are registered and fire on the same
// edge as the dout update.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst      in   synchronous, active-high reset
//   din      in   raw asynchronous input bit
//   dout     out  debounced level
//   rise     out  one-cycle pulse when dout goes 0->1
//   fall     out  one-cycle pulse when dout goes 1->0
//   pending  out  synchronised value differs from dout
// -----------------------------------------------------------------------------
module debounce_lane
    import seq_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic pending
);

    localparam int CW = cnt_width(STABLE_CYCLES);

    // Count value at which the candidate has been seen STABLE_CYCLES times
    // (the first differing sample is counted as 0).
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    logic [CW-1:0] cnt_q,  cnt_d;
    logic          dout_q, dout_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    lane_act_e     act;

    // -------------------------------------------------------------------------
    // Synchroniser. Bit 0 is the metastability-exposed capture flop; only the
    // last stage is ever looked at by the filter.
    // -------------------------------------------------------------------------
    // NOTE: clocked state is written with <= so every flop samples the
    // pre-edge value of its neighbour; with = the chain would collapse into a
    // single stage in simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Filter decision and next-state
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        act    = ACT_HOLD;
        cnt_d  = '0;
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;

        if (s != dout_q) begin
            if (cnt_q == CNT_LAST) begin
                act = ACT_COMMIT;
            end else begin
                act = ACT_COUNT;
            end
        end

        case (act)
            ACT_COUNT: begin
                // Cannot overflow: ACT_COMMIT is taken at CNT_LAST instead.
                cnt_d = cnt_q + CW'(1);
            end
            ACT_COMMIT: begin
                dout_d = s;
                rise_d = s;
                fall_d = ~s;
            end
            default: begin
                // ACT_HOLD: a sample that agrees with dout discards any
                // partial count, which is what rejects glitches.
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout    = dout_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign pending = s ^ dout_q;

endmodule : debounce_lane

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Multi-lane input conditioner feeding the flip-flop banks. Each of WIDTH
// independent lanes synchronises a raw asynchronous bit into clk and filters
// out bounce, producing a clean level plus registered one-cycle rise/fall
// pulses usable directly as t or j/k enables.
//
// Parameters:
//   WIDTH          number of lanes (>=1)
//   SYNC_STAGES    synchroniser depth per lane (>=2)
//   STABLE_CYCLES  post-sync cycles a new value must hold before dout moves (>=1)
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst      in   synchronous, active-high reset
//   din      in   [WIDTH] raw asynchronous inputs
//   dout     out  [WIDTH] debounced level per lane
//   rise     out  [WIDTH] one-cycle pulse, lane went 0->1
//   fall     out  [WIDTH] one-cycle pulse, lane went 1->0
//   pending  out  [WIDTH] synchronised value differs from dout
// -----------------------------------------------------------------------------
module input_debouncer
    import seq_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] pending
);

    // Reject configurations the lane logic cannot represent.
    if (WIDTH < 1) begin : g_bad_width
        $error("input_debouncer: WIDTH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("input_debouncer: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("input_debouncer: STABLE_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        debounce_lane #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .din    (din[i]),
            .dout   (dout[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .pending(pending[i])
        );
    end

endmodule : input_debouncer

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Directed bench for input_debouncer. Two instances share clk and rst:
//   u_dut   default parameters (SYNC_STAGES=2, STABLE_CYCLES=8)
//   u_var   STABLE_CYCLES=1, no filtering
// Expected outputs for the next edge are queued as stimulus is driven and are
// popped and compared 1 ns after that edge.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

    localparam int W        = 4;
    localparam int LAT_MAIN = 2 + 8;  // sync depth + stable cycles
    localparam int LAT_VAR  = 2 + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din_a = '0;
    logic [W-1:0] din_b = '0;

    logic [W-1:0] a_dout, a_rise, a_fall, a_pending;
    logic [W-1:0] b_dout, b_rise, b_fall, b_pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        tag;
        bit           variant;
        logic [W-1:0] dout;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] pending;
    } exp_t;

    exp_t sb[$];

    input_debouncer #(
        .WIDTH        (W),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(8)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din_a),
        .dout   (a_dout),
        .rise   (a_rise),
        .fall   (a_fall),
        .pending(a_pending)
    );

    input_debouncer #(
        .WIDTH        (W),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(1)
    ) u_var (
        .clk    (clk),
        .rst    (rst),
        .din    (din_b),
        .dout   (b_dout),
        .rise   (b_rise),
        .fall   (b_fall),
        .pending(b_pending)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input bit variant,
                            input logic [W-1:0] d, input logic [W-1:0] r,
                            input logic [W-1:0] f, input logic [W-1:0] p);
        exp_t e;
        e.tag     = tag;
        e.variant = variant;
        e.dout    = d;
        e.rise    = r;
        e.fall    = f;
        e.pending = p;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field,
                       input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, field, obs, exp_v);
        end
    endtask

    // Advance one rising edge, then compare everything queued for it.
    task automatic edge_and_check();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.variant) begin
                cmp(e.tag, "dout",    b_dout,    e.dout);
                cmp(e.tag, "rise",    b_rise,    e.rise);
                cmp(e.tag, "fall",    b_fall,    e.fall);
                cmp(e.tag, "pending", b_pending, e.pending);
            end else begin
                cmp(e.tag, "dout",    a_dout,    e.dout);
                cmp(e.tag, "rise",    a_rise,    e.rise);
                cmp(e.tag, "fall",    a_fall,    e.fall);
                cmp(e.tag, "pending", a_pending, e.pending);
            end
        end
    endtask

    // Drive a held level change from 'from' to 'to' and check n edges.
    // Edge 1 is the first edge sampling the new value; pending is visible from
    // edge 2 until dout updates on edge 'lat'.
    task automatic run_step(input string tag, input bit variant, input int lat,
                            input logic [W-1:0] from, input logic [W-1:0] to,
                            input int n);
        logic [W-1:0] chg;
        chg = from ^ to;
        if (variant) din_b = to;
        else         din_a = to;
        for (int e = 1; e <= n; e++) begin
            push_exp(tag, variant,
                     (e >= lat) ? to : from,
                     (e == lat) ? (chg & to)   : '0,
                     (e == lat) ? (chg & from) : '0,
                     (e >= 2 && e < lat) ? chg : '0);
            edge_and_check();
        end
    endtask

    initial begin
        logic bv_prev;
        logic bv;

        // ---------------- reset held with all inputs high -------------------
        rst   = 1'b1;
        din_a = 4'b1111;
        din_b = 4'b0000;
        #1;
        for (int e = 1; e <= 2; e++) begin
            push_exp("reset",   1'b0, '0, '0, '0, '0);
            push_exp("reset_v", 1'b1, '0, '0, '0, '0);
            edge_and_check();
        end
        rst = 1'b0;
        run_step("rst_release", 1'b0, LAT_MAIN, 4'b0000, 4'b1111, 11);

        // ---------------- fall on upper lanes -------------------------------
        run_step("fall", 1'b0, LAT_MAIN, 4'b1111, 4'b0011, 11);
        run_step("to_zero", 1'b0, LAT_MAIN, 4'b0011, 4'b0000, 11);

        // ---------------- clean step ----------------------------------------
        run_step("clean_step", 1'b0, LAT_MAIN, 4'b0000, 4'b0101, 11);
        run_step("clear", 1'b0, LAT_MAIN, 4'b0101, 4'b0000, 11);

        // ---------------- bounce on lane 0 ----------------------------------
        // din[0] = 1,0,1,0,1 on edges 1..5, then held at 1. The final 0->1
        // sample is edge 5, so dout[0] must rise on edge 14.
        bv_prev = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            bv = (k <= 5) ? k[0] : 1'b1;
            din_a = {3'b000, bv};
            push_exp("bounce", 1'b0,
                     (k >= 14) ? 4'b0001 : 4'b0000,
                     (k == 14) ? 4'b0001 : 4'b0000,
                     4'b0000,
                     (k >= 2 && k < 14) ? {3'b000, bv_prev} : 4'b0000);
            edge_and_check();
            bv_prev = bv;
        end

        // ---------------- reset mid-count on lane 3 -------------------------
        din_a = 4'b1001;
        for (int k = 1; k <= 5; k++) begin
            push_exp("midcnt", 1'b0, 4'b0001, '0, '0,
                     (k >= 2) ? 4'b1000 : 4'b0000);
            edge_and_check();
        end
        rst = 1'b1;
        push_exp("midcnt_rst", 1'b0, '0, '0, '0, '0);
        edge_and_check();
        rst = 1'b0;
        run_step("post_rst", 1'b0, LAT_MAIN, 4'b0000, 4'b1001, 11);

        // ---------------- STABLE_CYCLES=1 variant ---------------------------
        // One-cycle 1010 pulse: it survives synchronisation, so it reaches
        // dout for exactly one cycle.
        din_b = 4'b1010;
        push_exp("glitch_e1", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        edge_and_check();
        din_b = 4'b0000;
        push_exp("glitch_e2", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1010);
        edge_and_check();
        push_exp("glitch_e3", 1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b1010);
        edge_and_check();
        push_exp("glitch_e4", 1'b1, 4'b0000, 4'b0000, 4'b1010, 4'b0000);
        edge_and_check();
        push_exp("glitch_e5", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        edge_and_check();

        run_step("var_step", 1'b1, LAT_VAR, 4'b0000, 4'b0110, 4);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_input_debouncer
